// File: rtl/conv3x3_mac_engine.sv
// rtl/conv3x3_mac_engine.sv - serial 3x3 convolution MAC with rounding, saturation and optional ReLU
module conv3x3_mac_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 36,
    parameter int RELU_EN    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] win_data,
    input  logic [DATA_WIDTH-1:0]   w0,
    input  logic [DATA_WIDTH-1:0]   w1,
    input  logic [DATA_WIDTH-1:0]   w2,
    input  logic [DATA_WIDTH-1:0]   w3,
    input  logic [DATA_WIDTH-1:0]   w4,
    input  logic [DATA_WIDTH-1:0]   w5,
    input  logic [DATA_WIDTH-1:0]   w6,
    input  logic [DATA_WIDTH-1:0]   w7,
    input  logic [DATA_WIDTH-1:0]   w8,
    input  logic [DATA_WIDTH-1:0]   bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    // Rounding constant and saturation bounds, all at accumulator width + 1 so the
    // rounding add can never wrap.
    localparam logic signed [AW:0] RND_HALF =
        {{(AW + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
    localparam logic signed [AW:0] SAT_MAX =
        {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN =
        {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0] MAX_D = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] MIN_D = {1'b1, {(DW - 1){1'b0}}};
    localparam logic [3:0]    LAST_TAP = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FIN,
        S_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             tap_q, tap_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [9*DW-1:0]        win_q, win_d;
    logic [9*DW-1:0]        wt_q, wt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DW-1:0]          out_data_q, out_data_d;

    logic [DW-1:0]          pix_sel;
    logic [DW-1:0]          wt_sel;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW:0]     rnd_sum;
    logic signed [AW:0]     rnd_shift;
    logic [DW-1:0]          sat_val;
    logic [DW-1:0]          result;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Current tap operands and their full-precision signed product
    always_comb begin
        pix_sel  = win_q[tap_q*DW +: DW];
        wt_sel   = wt_q[tap_q*DW +: DW];
        prod     = $signed(pix_sel) * $signed(wt_sel);
        prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    end

    // Round half up, saturate to the output range, then optional ReLU
    always_comb begin
        rnd_sum   = {acc_q[AW-1], acc_q} + RND_HALF;
        rnd_shift = rnd_sum >>> FRAC_BITS;
        if (rnd_shift > SAT_MAX) begin
            sat_val = MAX_D;
        end else if (rnd_shift < SAT_MIN) begin
            sat_val = MIN_D;
        end else begin
            sat_val = rnd_shift[DW-1:0];
        end
        if ((RELU_EN != 0) && sat_val[DW-1]) begin
            result = '0;
        end else begin
            result = sat_val;
        end
    end

    // Next-state and datapath update for IDLE -> MAC -> FIN -> OUT
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        win_d       = win_q;
        wt_d        = wt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = win_data;
                    wt_d    = {w8, w7, w6, w5, w4, w3, w2, w1, w0};
                    acc_d   = {{(AW - DW - FRAC_BITS){bias[DW-1]}}, bias, {FRAC_BITS{1'b0}}};
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = S_FIN;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_FIN: begin
                out_data_d  = result;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any window in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            wt_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
            wt_q        <= wt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
